rv_muldiv_iter: RTL

- Parametrised iterative RV M-extension unit: MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Successor to the single-width internal multiply/divide path of the execute stage.
- Generalised in XLEN and in radix (bits retired per cycle).
- Replaces the pulse/stall coupling with an explicit valid/ready/ack handshake, plus kill and single-cycle special-case paths.

---
 rtl/rv_muldiv_iter.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/rv_muldiv_iter.sv
// Iterative RV M-extension multiply/divide unit: sign-magnitude shift-add multiply and
// restoring divide, BITS_PER_CYCLE bits per iteration, with valid/ready/ack handshake and kill.
module rv_muldiv_iter #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic [2:0]      i_f3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic            i_kill,
    input  logic            i_ack,
    output logic            o_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_res,
    output logic            o_stall
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int R  = BITS_PER_CYCLE;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nx_s;
    logic [2:0]          f3_r;
    logic [XLEN-1:0]     op_r;
    logic [2*XLEN-1:0]   acc_r;
    logic                neg_q_r;
    logic                neg_r_r;
    logic [CW-1:0]       cnt_r;
    logic [XLEN-1:0]     res_r;
    logic                valid_r;
    logic                ready_r;

    logic                is_div_s;
    logic                a_signed_s;
    logic                b_signed_s;
    logic                a_neg_s;
    logic                b_neg_s;
    logic [XLEN-1:0]     a_mag_s;
    logic [XLEN-1:0]     b_mag_s;
    logic                div0_s;
    logic                ovf_s;
    logic                special_s;
    logic [XLEN-1:0]     spec_res_s;

    logic [XLEN+R-1:0]   partial_s;
    logic [XLEN+R-1:0]   hi_sum_s;
    logic [2*XLEN-1:0]   mul_next_s;
    logic [2*XLEN-1:0]   div_next_s;
    logic [XLEN:0]       sh_s;
    logic [XLEN:0]       diff_s;
    logic [2*XLEN-1:0]   step_s;
    logic [2*XLEN-1:0]   mul_fix_s;
    logic [XLEN-1:0]     quo_s;
    logic [XLEN-1:0]     rem_s;
    logic [XLEN-1:0]     final_res_s;

    logic                accept_s;
    logic                spec_load_s;
    logic                iter_s;
    logic                finish_s;

    // Operand decode: signedness, magnitudes and single-cycle special cases.
    always_comb begin
        is_div_s   = i_f3[2];
        a_signed_s = is_div_s ? ~i_f3[0] : (i_f3[1:0] != 2'b11);
        b_signed_s = is_div_s ? ~i_f3[0] : ~i_f3[1];
        a_neg_s    = a_signed_s & i_rs1[XLEN-1];
        b_neg_s    = b_signed_s & i_rs2[XLEN-1];
        a_mag_s    = a_neg_s ? (~i_rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : i_rs1;
        b_mag_s    = b_neg_s ? (~i_rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : i_rs2;
        div0_s     = is_div_s & (i_rs2 == {XLEN{1'b0}});
        ovf_s      = is_div_s & ~i_f3[0] & (i_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                     & (i_rs2 == {XLEN{1'b1}});
        special_s  = div0_s | ovf_s;
        if (div0_s) begin
            spec_res_s = i_f3[1] ? i_rs1 : {XLEN{1'b1}};
        end else begin
            spec_res_s = i_f3[1] ? {XLEN{1'b0}} : i_rs1;
        end
    end

    // One iteration of shift-add multiply and restoring divide, plus final sign correction.
    always_comb begin
        partial_s = {(XLEN+R){1'b0}};
        for (int j = 0; j < R; j++) begin
            if (acc_r[j]) begin
                partial_s = partial_s + ({{R{1'b0}}, op_r} << j);
            end else begin
                partial_s = partial_s;
            end
        end
        hi_sum_s   = {{R{1'b0}}, acc_r[2*XLEN-1:XLEN]} + partial_s;
        mul_next_s = {hi_sum_s, acc_r[XLEN-1:R]};

        div_next_s = acc_r;
        sh_s       = {(XLEN+1){1'b0}};
        diff_s     = {(XLEN+1){1'b0}};
        for (int i = 0; i < R; i++) begin
            sh_s   = {div_next_s[2*XLEN-1:XLEN], div_next_s[XLEN-1]};
            diff_s = sh_s - {1'b0, op_r};
            if (!diff_s[XLEN]) begin
                div_next_s = {diff_s[XLEN-1:0], div_next_s[XLEN-2:0], 1'b1};
            end else begin
                div_next_s = {sh_s[XLEN-1:0], div_next_s[XLEN-2:0], 1'b0};
            end
        end

        step_s    = f3_r[2] ? div_next_s : mul_next_s;
        mul_fix_s = neg_q_r ? (~step_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : step_s;
        quo_s     = neg_q_r ? (~step_s[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                            : step_s[XLEN-1:0];
        rem_s     = neg_r_r ? (~step_s[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                            : step_s[2*XLEN-1:XLEN];
        if (f3_r[2]) begin
            final_res_s = f3_r[1] ? rem_s : quo_s;
        end else begin
            final_res_s = (f3_r[1:0] == 2'b00) ? mul_fix_s[XLEN-1:0]
                                               : mul_fix_s[2*XLEN-1:XLEN];
        end
    end

    // Next-state and control strobes; kill outranks ack and acceptance.
    always_comb begin
        state_nx_s  = state_r;
        accept_s    = 1'b0;
        spec_load_s = 1'b0;
        iter_s      = 1'b0;
        finish_s    = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_valid && !i_kill) begin
                    if (special_s) begin
                        spec_load_s = 1'b1;
                        state_nx_s  = ST_DONE;
                    end else begin
                        accept_s   = 1'b1;
                        state_nx_s = ST_BUSY;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (i_kill) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    iter_s = 1'b1;
                    if (cnt_r == CW'(N-1)) begin
                        finish_s   = 1'b1;
                        state_nx_s = ST_DONE;
                    end else begin
                        state_nx_s = ST_BUSY;
                    end
                end
            end
            ST_DONE: begin
                if (i_kill || i_ack) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_DONE;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == ST_IDLE);
            valid_r <= (state_nx_s == ST_DONE);
        end
    end

    // Operand capture and per-iteration datapath update.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            f3_r    <= 3'b000;
            op_r    <= {XLEN{1'b0}};
            acc_r   <= {(2*XLEN){1'b0}};
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            cnt_r   <= {CW{1'b0}};
        end else if (accept_s) begin
            f3_r    <= i_f3;
            op_r    <= is_div_s ? b_mag_s : a_mag_s;
            acc_r   <= {{XLEN{1'b0}}, (is_div_s ? a_mag_s : b_mag_s)};
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            cnt_r   <= {CW{1'b0}};
        end else if (iter_s) begin
            acc_r <= step_s;
            cnt_r <= finish_s ? {CW{1'b0}} : (cnt_r + CW'(1));
        end else begin
            cnt_r <= {CW{1'b0}};
        end
    end

    // Result register: loaded by a special case or on the final iteration, else held.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            res_r <= {XLEN{1'b0}};
        end else if (spec_load_s) begin
            res_r <= spec_res_s;
        end else if (finish_s) begin
            res_r <= final_res_s;
        end else begin
            res_r <= res_r;
        end
    end

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_res   = res_r;
    assign o_stall = i_valid & ~valid_r;

endmodule
